// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths, grant encoding and write-request record for the register-file
// write-port arbiter and its MDU result FIFO.
package rf_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MDU  = 2'd2,
    GNT_DBG  = 2'd3
  } gnt_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  localparam int WR_REQ_W = $bits(wr_req_t);

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO holding MDU results until they win the register-file port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rf_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; empty pointers guarantee it is never read stale.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Single write port of the 32x32 register file shared by writeback, buffered
// MDU results and debug, with an MDU pending scoreboard and starvation stall.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0]     mdu_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] q_rs,
  input  logic [REG_ADDR_W-1:0] q_rt,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  sb_stall,
  output logic                  stall_req,
  input  logic                  dbg_req,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_data,
  output logic                  dbg_ack,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  wr_req_t              mdu_in, head, win;
  logic                 fifo_full, fifo_empty, push, pop;
  gnt_e                 gnt;
  logic [NUM_REGS-1:0]  pend_q, pend_d, pend_vis;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 stall_q, stall_d;
  logic                 dbg_ack_q;

  assign mdu_in    = '{addr: mdu_addr, data: mdu_data};
  assign mdu_ready = !fifo_full;
  assign push      = mdu_valid && mdu_ready;
  assign pop       = (gnt == GNT_MDU);

  rf_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WR_REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (mdu_in),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // A debug request still high during its ack cycle must not be granted twice.
  always_comb begin
    gnt = GNT_NONE;
    if (wb_valid)                    gnt = GNT_WB;
    else if (!fifo_empty)            gnt = GNT_MDU;
    else if (dbg_req && !dbg_ack_q)  gnt = GNT_DBG;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    win = '0;
    case (gnt)
      GNT_WB:  win = '{addr: wb_addr, data: wb_data};
      GNT_MDU: win = head;
      GNT_DBG: win = '{addr: dbg_addr, data: dbg_data};
      default: win = '0;
    endcase
  end

  assign rf_we    = (gnt != GNT_NONE) && (win.addr != '0);
  assign rf_waddr = win.addr;
  assign rf_wdata = win.data;

  // The register being written this cycle is already visible to decode.
  always_comb begin
    pend_vis = pend_q;
    if (pop) pend_vis[head.addr] = 1'b0;
    pend_d = pend_vis;
    if (iss_valid) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  assign sb_stall = pend_vis[q_rs] | pend_vis[q_rt] | pend_vis[q_rd];

  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else if (starve_q == STARVE_LAST) begin
      stall_d  = 1'b1;
    end else begin
      starve_d = starve_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      dbg_ack_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      dbg_ack_q <= (gnt == GNT_DBG);
    end
  end

  assign stall_req = stall_q;
  assign dbg_ack   = dbg_ack_q;

endmodule
